muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair. It serves mult, multu, div, divu, mthi and mtlo for the multicycle core. The main control FSM issues an operation with a start pulse and stalls on busy until done. mfhi/mflo read the hi/lo outputs directly.

Parameters:
DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W.
DIV0_LO, 32'hFFFF_FFFF, value written to LO on divide by zero.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; synchronous, active-high.
start  in  1  one-cycle issue strobe.
op  in  3  operation code (muldiv_pkg).
rs_data  in  DATA_W  operand A: multiplicand / dividend / mthi-mtlo source.
rt_data  in  DATA_W  operand B: multiplier / divisor.
flush  in  1  cancel any in-flight operation (exception path).
busy  out  1  operation in progress.
done  out  1  one-cycle pulse; HI/LO hold the new result.
hi  out  DATA_W  HI register.
lo  out  DATA_W  LO register.

Behaviour:
- Reset (synchronous, rst high at a clk edge): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards the operation.
- op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops (start ignored).
- start is accepted only in IDLE with flush=0. start while busy is ignored, with no effect on the running operation.
- MTHI/MTLO: accepted at edge k → hi (or lo) = rs_data after edge k. No busy, no done.
- MULT/MULTU/DIV/DIVU: accepted at edge k. Operands are latched, signed ops convert to magnitudes, counter=DATA_W-1, state CALC, busy=1 from edge k.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for DATA_W edges (k+1..k+32). At the last step, state goes to FIX.
- FIX, edge k+33:
  - Signed ops apply sign correction.
  - hi/lo are written, busy=0, done=1 for exactly one cycle, state returns to IDLE.
  - Total latency is 33 cycles from accept to done.
- Multiply result: {hi,lo} = full 64-bit product. It is a two's-complement product for MULT and unsigned for MULTU.
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient sign = sign(rs) XOR sign(rt).
  - Signed remainder sign = sign(rs).
  - Truncation is toward zero.
- Signed overflow (0x80000000 / 0xFFFFFFFF) gives lo=0x80000000, hi=0.
- Divide by zero (rt=0) keeps the same 33-cycle latency: lo=DIV0_LO, hi=rs_data. It is not an exception.
- flush=1 in any state:
  - Next edge: state IDLE, busy=0, no done, hi/lo unchanged.
  - flush together with start in IDLE means nothing is accepted.
  - flush in the FIX cycle suppresses the write.
- done and start in the same cycle: start is accepted (state is already IDLE).
- hi/lo change only on an MTHI/MTLO accept or a FIX write.

Decomposition:
- muldiv_pkg holds the op code constants (MD_MULT..MD_MTLO) and the state encoding (IDLE, CALC, FIX).
- Sub-module muldiv_iter holds the shift registers: 64-bit accumulator/remainder, 32-bit operand register, add/subtract step, and the magnitude/negate helpers.
- muldiv_ctrl holds the FSM, counter, handshake, flush handling and the HI/LO registers.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) → busy for 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=0x0000000E, hi=0x00000002. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=0x00001234, rt=0 → done after 33 cycles; lo=0xFFFFFFFF, hi=0x00001234.
- MTHI rs=0xDEADBEEF → hi updated the next cycle, busy stays 0. Then MTLO rs=1 → lo=1. MTHI issued during a MULT → ignored; hi stays at the MULT result.
- Start MULTU 3×5; flush at cycle 10 → busy=0 the next cycle, no done, hi/lo keep their prior values. A new start issued while busy is not accepted.
- rst at cycle 20 of a DIV → after the edge: busy=0, done=0, hi=lo=0. A fresh MULT 2×2 then gives lo=4, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op-class decode helpers for the
// iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Codes 0..3 are the iterative ops; bit 1 selects divide, bit 0 unsigned.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Datapath for the multiply/divide sequencer: operand magnitudes, one
// shift-add or restoring shift-subtract step per cycle, and final sign fix-up.
module muldiv_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    localparam int W = DATA_W;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        return ~x + W'(1);
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
        return ~x + (2*W)'(1);
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? neg_w(x) : x;
    endfunction

    logic [2*W-1:0] acc_reg;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   opnd_reg;
    logic           div_reg;
    logic           neg_lo_reg;
    logic           neg_hi_reg;

    logic [W:0]     sum;
    logic [W:0]     shl;
    logic [W-1:0]   diff;
    logic           ge;
    logic [2*W-1:0] prod;

    // acc holds {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    always_comb begin
        sum  = {1'b0, acc_reg[2*W-1:W]} + {1'b0, opnd_reg};
        shl  = {acc_reg[2*W-1:W], acc_reg[W-1]};
        ge   = (shl >= {1'b0, opnd_reg});
        diff = shl[W-1:0] - opnd_reg;
        acc_next = acc_reg;
        if (div_reg) begin
            if (ge)
                acc_next = {diff, acc_reg[W-2:0], 1'b1};
            else
                acc_next = {shl[W-1:0], acc_reg[W-2:0], 1'b0};
        end else begin
            if (acc_reg[0])
                acc_next = {sum, acc_reg[W-1:1]};
            else
                acc_next = {1'b0, acc_reg[2*W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg    <= '0;
            opnd_reg   <= '0;
            div_reg    <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
        end else if (load) begin
            acc_reg    <= {{W{1'b0}}, mag(a, is_signed)};
            opnd_reg   <= mag(b, is_signed);
            div_reg    <= is_div;
            neg_lo_reg <= is_signed & (a[W-1] ^ b[W-1]);
            neg_hi_reg <= is_signed & (is_div ? a[W-1] : (a[W-1] ^ b[W-1]));
        end else if (step) begin
            acc_reg <= acc_next;
        end
    end

    // Remainder takes the dividend's sign; quotient and product take the XOR.
    always_comb begin
        prod   = neg_lo_reg ? neg_2w(acc_reg) : acc_reg;
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
        if (div_reg) begin
            res_hi = neg_hi_reg ? neg_w(acc_reg[2*W-1:W]) : acc_reg[2*W-1:W];
            res_lo = neg_lo_reg ? neg_w(acc_reg[W-1:0]) : acc_reg[W-1:0];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: issue handshake, FSM, iteration counter, flush
// handling and the architectural HI/LO registers.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int              DATA_W  = 32,
    parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;
    logic [DATA_W-1:0] rs_reg;
    logic              div0_reg;

    logic              accept;
    logic              load_arith;
    logic              step;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;

    assign accept     = (state_reg == ST_IDLE) && start && !flush;
    assign load_arith = accept && op_is_arith(op);
    assign step       = (state_reg == ST_CALC) && !flush;

    muldiv_iter #(
        .DATA_W (DATA_W)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (load_arith),
        .step      (step),
        .is_div    (op_is_div(op)),
        .is_signed (op_is_signed(op)),
        .a         (rs_data),
        .b         (rt_data),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            rs_reg    <= '0;
            div0_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (flush) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (load_arith) begin
                            state_reg <= ST_CALC;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= CNT_W'(DATA_W - 1);
                            rs_reg    <= rs_data;
                            div0_reg  <= op_is_div(op) && (rt_data == '0);
                        end else if (accept && op == MD_MTHI) begin
                            hi_reg <= rs_data;
                        end else if (accept && op == MD_MTLO) begin
                            lo_reg <= rs_data;
                        end
                    end
                    ST_CALC: begin
                        if (cnt_reg == '0)
                            state_reg <= ST_FIX;
                        else
                            cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                    ST_FIX: begin
                        // Divide by zero runs the full sequence but reports fixed values.
                        if (div0_reg) begin
                            hi_reg <= rs_reg;
                            lo_reg <= DIV0_LO;
                        end else begin
                            hi_reg <= res_hi;
                            lo_reg <= res_lo;
                        end
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
